fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR sequencer for the pulse-shaping and matched-filter path. It shares one external Q2.13 signed multiply unit across all taps.
- Holds the sample delay line and the coefficient bank. For each accepted input symbol it steps through every tap, accumulates the products, and emits one saturated Q2.13 output.
- Sits between the symbol source and the modulator/decision logic.

Parameters:
- NTAPS, 8, number of filter taps (legal 2..64).
- DW, 16, sample/coefficient/product width, signed Q2.13.
- AW, 6, coefficient address width; must satisfy 2**AW >= NTAPS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_sample  in  DW  signed Q2.13 input sample.
- out_valid  out  1  filtered output valid.
- out_ready  in  1  downstream accepts output.
- out_sample  out  DW  signed Q2.13 filtered, saturated output.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  tap index to write.
- coef_data  in  DW  signed Q2.13 coefficient.
- cfg_err  out  1  one-cycle pulse on a rejected config action.
- flush  in  1  clear delay line.
- mul_a  out  DW  multiplier operand (delay-line sample).
- mul_b  out  DW  multiplier operand (coefficient).
- mul_p  in  DW  multiplier result: (mul_a*mul_b)>>>13, truncated to DW, combinational.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE; out_valid=0; out_sample=0; cfg_err=0; busy=0; mul_a=0; mul_b=0; all delay-line entries=0; all coefficients=0; wr_ptr=0; tap counter k=0; accumulator=0. in_ready=1 once reset is released.
- in_ready is high only in IDLE with flush=0.
- State machine:
  - IDLE -> MAC on in_valid&in_ready. At that edge: delay[wr_ptr]<=in_sample; rd_ptr<=wr_ptr; wr_ptr advances with wrap (NTAPS-1 -> 0); k<=0; acc<=0.
  - MAC: one tap per cycle. mul_a=delay[rd_ptr] and mul_b=coef[k], both combinational from the registers. Each edge: acc<=acc+sext(mul_p); rd_ptr decrements with wrap (0 -> NTAPS-1); k increments.
  - MAC -> OUT on the edge where k==NTAPS-1. At that edge out_sample<=sat(acc+sext(mul_p)) and out_valid<=1.
  - OUT: out_valid and out_sample are held stable until out_ready. On out_valid&out_ready: out_valid<=0, state -> IDLE.
- Latency: out_valid rises on the NTAPS-th rising edge after the accepting edge. Throughput is one sample per NTAPS+2 cycles with out_ready tied high.
- Operand values outside MAC: mul_a and mul_b are driven 0.
- Accumulator: signed, DW+clog2(NTAPS) bits, so it cannot overflow internally. Each product is sign-extended before adding.
- Saturation: clamp the final sum to [-32768, 32767] for DW=16 (generally [-2**(DW-1), 2**(DW-1)-1]).
- Coefficient writes: accepted only in IDLE (coef[coef_addr]<=coef_data). Rejected cases, which leave the bank unchanged and pulse cfg_err for one cycle:
  - coef_we outside IDLE;
  - coef_addr >= NTAPS.
- Flush: honoured only in IDLE. It zeroes all delay-line entries and wr_ptr in one cycle; coefficients are unaffected.
  - flush outside IDLE is ignored and pulses cfg_err.
  - flush with in_valid in the same cycle: flush wins and the sample is not accepted (in_ready=0).
  - flush with coef_we in the same cycle in IDLE: both take effect.
- Reset mid-operation: rst_n low forces all registers to their reset values immediately, regardless of state. Any partial accumulation is discarded.

Decomposition:
- Shared package fir_pkg holds:
  - sample_t (signed [15:0]);
  - Q_FRAC=13;
  - Q_ONE=16'sh2000;
  - SAT_MAX/SAT_MIN;
  - the state enum {IDLE, MAC, OUT};
  - a saturate function.
- One natural sub-module: fir_coef_bank, the coefficient register file with a write port, a combinational read port and the address range check.
- The multiplier stays external. The top level connects mul_a/mul_b/mul_p to the existing multiply instance.

Test Plan:
1. Reset: assert rst_n=0 mid-MAC -> outputs reset to 0 immediately. After release, in_ready=1, out_valid=0, busy=0.
2. Impulse response (NTAPS=8):
   - stimulus: coef[k]=1000*(k+1); feed 8192, then 7 zeros, out_ready=1;
   - required: out_sample sequence 1000, 2000, …, 8000;
   - required: each out_valid rises exactly 8 edges after its accept.
3. Saturation:
   - stimulus: all coef=8192; feed 16000 three times;
   - required: outputs 16000, 32000, 32767;
   - stimulus: flush, then feed -16000 three times;
   - required: outputs -16000, -32000, -32768.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_sample stable, in_ready=0, busy=1. Raising out_ready completes the transfer and in_ready=1 on the next cycle.
5. Config protection:
   - coef_we during MAC -> cfg_err pulses once and the current and next outputs are unchanged;
   - coef_addr=8 in IDLE -> cfg_err pulses and no write occurs.
6. Flush/valid collision: flush=1 and in_valid=1 in the same IDLE cycle -> sample not accepted, delay line zeroed. A subsequent impulse reproduces the scenario-2 sequence.

Source files
------------

// File: rtl/fir_pkg.sv
`timescale 1ns/1ps
// fir_pkg: shared types and constants for the time-multiplexed FIR sequencer.
//   sample_t     : signed Q2.13 sample/coefficient/product word
//   Q_FRAC/Q_ONE : fixed-point format (13 fraction bits, 1.0 = 0x2000)
//   SAT_MAX/MIN  : clamp bounds of a 16-bit Q2.13 word
//   state_t      : sequencer states IDLE / MAC / OUT
//   saturate()   : clamps a wide signed value into a dw-bit signed range
package fir_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int      Q_FRAC  = 13;
  localparam sample_t Q_ONE   = 16'sh2000;
  localparam sample_t SAT_MAX = 16'sh7fff;
  localparam sample_t SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Clamp val to [-2**(dw-1), 2**(dw-1)-1]; the caller truncates to dw bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                  input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (val > hi) begin
      saturate = hi;
    end else if (val < lo) begin
      saturate = lo;
    end else begin
      saturate = val;
    end
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_coef_bank.sv
`timescale 1ns/1ps
// fir_coef_bank: coefficient register file for the FIR sequencer.
//   clk, rst_n : clock, asynchronous active-low reset (bank clears to 0)
//   wr_en      : write request, already qualified by the caller as legal-state
//   wr_addr    : tap index to write; indices >= NTAPS are refused
//   wr_data    : coefficient value
//   rd_addr    : tap index for the combinational read port
//   rd_data    : coefficient at rd_addr
//   range_err  : wr_en with an out-of-range wr_addr (combinational)
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW    = 16,
  parameter int AW    = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  input  logic [$clog2(NTAPS)-1:0]   rd_addr,
  output logic [DW-1:0]              rd_data,
  output logic                       range_err
);

  localparam int KW = $clog2(NTAPS);

  logic [DW-1:0] coef_r [NTAPS];
  logic          addr_ok_s;

  // One extra bit so NTAPS itself is representable when NTAPS == 2**AW.
  assign addr_ok_s = ({1'b0, wr_addr} < (AW+1)'(NTAPS));
  assign range_err = wr_en & ~addr_ok_s;

  // Coefficient storage: decoded write, refused when the address is out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        if (wr_en && addr_ok_s && (wr_addr == AW'(i))) begin
          coef_r[i] <= wr_data;
        end
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (rd_addr == KW'(i)) begin
        rd_data = coef_r[i];
      end else begin
        rd_data = rd_data;
      end
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
`timescale 1ns/1ps
// fir_mac_sequencer: time-multiplexed FIR. Each accepted sample is written
// into a circular delay line, then NTAPS cycles of MAC through one shared
// external multiplier produce a saturated Q2.13 output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : sample input handshake; in_sample is Q2.13
//   out_valid/out_ready : result handshake; out_sample held until taken
//   coef_we/addr/data   : coefficient write port (legal only in IDLE)
//   cfg_err             : one-cycle pulse on a refused write or flush
//   flush               : clears delay line and write pointer (IDLE only)
//   mul_a/mul_b/mul_p   : external multiplier operands and (a*b)>>>13 result
//   busy                : sequencer not in IDLE
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW    = 16,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sample,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sample,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [DW-1:0] coef_data,
  output logic          cfg_err,
  input  logic          flush,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  input  logic [DW-1:0] mul_p,
  output logic          busy
);

  localparam int PW   = $clog2(NTAPS);
  localparam int ACCW = DW + PW;
  localparam logic [PW-1:0] LAST = PW'(NTAPS - 1);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [DW-1:0]          delay_r [NTAPS];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [PW-1:0]          k_r;
  logic signed [ACCW-1:0] acc_r;
  logic signed [ACCW-1:0] sum_s;
  logic signed [63:0]     sum64_s;
  logic [DW-1:0]          out_sample_r;
  logic                   out_valid_r;
  logic                   cfg_err_r;
  logic [DW-1:0]          coef_rd_s;
  logic                   idle_s;
  logic                   accept_s;
  logic                   range_err_s;

  assign idle_s   = (state_r == IDLE);
  assign accept_s = in_valid & in_ready;

  // Running sum including the current product, sign-extended to the accumulator width.
  assign sum_s   = acc_r + $signed({{(ACCW-DW){mul_p[DW-1]}}, mul_p});
  assign sum64_s = {{(64-ACCW){sum_s[ACCW-1]}}, sum_s};

  assign out_sample = out_sample_r;
  assign out_valid  = out_valid_r;
  assign cfg_err    = cfg_err_r;

  fir_coef_bank #(
    .NTAPS (NTAPS),
    .DW    (DW),
    .AW    (AW)
  ) u_coef_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (coef_we & idle_s),
    .wr_addr   (coef_addr),
    .wr_data   (coef_data),
    .rd_addr   (k_r),
    .rd_data   (coef_rd_s),
    .range_err (range_err_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = MAC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MAC: begin
        if (k_r == LAST) begin
          state_nxt_s = OUT;
        end else begin
          state_nxt_s = MAC;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State-decoded outputs; operands are forced to zero outside MAC.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    mul_a    = '0;
    mul_b    = '0;
    case (state_r)
      IDLE: begin
        in_ready = ~flush;
        busy     = 1'b0;
      end
      MAC: begin
        mul_a = delay_r[rd_ptr_r];
        mul_b = coef_rd_s;
      end
      OUT: begin
        in_ready = 1'b0;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Datapath: delay line, pointers, accumulator, output register, config error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        delay_r[i] <= '0;
      end
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      k_r          <= '0;
      acc_r        <= '0;
      out_sample_r <= '0;
      out_valid_r  <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      cfg_err_r <= ((coef_we | flush) & ~idle_s) | range_err_s;
      case (state_r)
        IDLE: begin
          // flush takes priority over an incoming sample (in_ready is low).
          if (flush) begin
            for (int i = 0; i < NTAPS; i++) begin
              delay_r[i] <= '0;
            end
            wr_ptr_r <= '0;
          end else if (in_valid) begin
            delay_r[wr_ptr_r] <= in_sample;
            rd_ptr_r          <= wr_ptr_r;
            wr_ptr_r          <= (wr_ptr_r == LAST) ? '0 : wr_ptr_r + PW'(1);
            k_r               <= '0;
            acc_r             <= '0;
          end
        end
        MAC: begin
          // Walk backwards through history: newest sample pairs with coef[0].
          acc_r    <= sum_s;
          rd_ptr_r <= (rd_ptr_r == '0) ? LAST : rd_ptr_r - PW'(1);
          k_r      <= k_r + PW'(1);
          if (k_r == LAST) begin
            out_sample_r <= DW'(saturate(sum64_s, DW));
            out_valid_r  <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
`timescale 1ns/1ps
// tb_fir_mac_sequencer: table-driven directed bench with an external
// Q2.13 multiplier model, plus hand-written multi-cycle corner cases.
module tb_fir_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sample;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;
  logic        coef_we;
  logic [5:0]  coef_addr;
  logic [15:0] coef_data;
  logic        cfg_err;
  logic        flush;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_p;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int                 coef_set;   // 0 keep, 1 ramp 1000*(k+1), 2 unity
    logic               pre_flush;
    logic signed [15:0] smp;
    logic signed [15:0] expv;
  } vec_t;

  vec_t tbl [14];

  // External multiplier: (a*b)>>>13 truncated to 16 bits.
  logic signed [31:0] prod;
  assign prod  = $signed(mul_a) * $signed(mul_b);
  assign mul_p = 16'(prod >>> 13);

  fir_mac_sequencer #(.NTAPS(8), .DW(16), .AW(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .cfg_err    (cfg_err),
    .flush      (flush),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coefs(input int mode);
    for (int k = 0; k < 8; k++) begin
      coef_we   = 1'b1;
      coef_addr = 6'(k);
      coef_data = (mode == 1) ? 16'(1000 * (k + 1)) : 16'sh2000;
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Feed one sample, check latency and value, let the handshake complete.
  task automatic send(input logic signed [15:0] s, input logic signed [15:0] e,
                      input string nm);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: in_ready stayed low, got 0, expected 1", nm);
    end
    in_valid  = 1'b1;
    in_sample = s;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({nm, " latency"}, lat, 8);
    check({nm, " out_sample"}, $signed(out_sample), e);
    tick();
  endtask

  initial begin
    tbl[0]  = '{1, 1'b1,  16'sd8192,  16'sd1000};
    tbl[1]  = '{0, 1'b0,  16'sd0,     16'sd2000};
    tbl[2]  = '{0, 1'b0,  16'sd0,     16'sd3000};
    tbl[3]  = '{0, 1'b0,  16'sd0,     16'sd4000};
    tbl[4]  = '{0, 1'b0,  16'sd0,     16'sd5000};
    tbl[5]  = '{0, 1'b0,  16'sd0,     16'sd6000};
    tbl[6]  = '{0, 1'b0,  16'sd0,     16'sd7000};
    tbl[7]  = '{0, 1'b0,  16'sd0,     16'sd8000};
    tbl[8]  = '{2, 1'b1,  16'sd16000, 16'sd16000};
    tbl[9]  = '{0, 1'b0,  16'sd16000, 16'sd32000};
    tbl[10] = '{0, 1'b0,  16'sd16000, 16'sd32767};
    tbl[11] = '{0, 1'b1, -16'sd16000, -16'sd16000};
    tbl[12] = '{0, 1'b0, -16'sd16000, -16'sd32000};
    tbl[13] = '{0, 1'b0, -16'sd16000, 16'sh8000};

    rst_n = 1'b0; in_valid = 1'b0; in_sample = 16'd0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = 6'd0; coef_data = 16'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_sample", $signed(out_sample), 0);
    check("rst busy", busy, 0);
    check("rst cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    tick();
    check("post-rst in_ready", in_ready, 1);

    // Impulse response and saturation vectors.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].coef_set != 0) load_coefs(tbl[i].coef_set);
      if (tbl[i].pre_flush) do_flush();
      send(tbl[i].smp, tbl[i].expv, $sformatf("vec%0d", i));
    end

    // Backpressure: result held while out_ready is low.
    begin
      int lat;
      do_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sample = 16'sd100;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
        tick();
        lat++;
      end
      check("bp latency", lat, 8);
      for (int c = 0; c < 5; c++) begin
        tick();
        check("bp out_sample held", $signed(out_sample), 100);
      end
      check("bp out_valid held", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp busy", busy, 1);
      out_ready = 1'b1;
      tick();
      check("bp out_valid cleared", out_valid, 0);
      check("bp in_ready back", in_ready, 1);
    end

    // Config protection: write during MAC refused, bad address refused.
    begin
      int lat;
      load_coefs(1);
      do_flush();
      in_valid  = 1'b1;
      in_sample = 16'sd8192;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      coef_we = 1'b1; coef_addr = 6'd1; coef_data = 16'd0;
      tick();
      coef_we = 1'b0;
      check("cfg mac cfg_err pulse", cfg_err, 1);
      tick();
      check("cfg mac cfg_err clear", cfg_err, 0);
      lat = 4;
      while (!out_valid && lat < 40) begin
        tick();
        lat++;
      end
      check("cfg latency", lat, 8);
      check("cfg current out", $signed(out_sample), 1000);
      tick();
      send(16'sd0, 16'sd2000, "cfg next");
      coef_we = 1'b1; coef_addr = 6'd8; coef_data = 16'sd123;
      tick();
      coef_we = 1'b0;
      check("cfg addr8 cfg_err pulse", cfg_err, 1);
      tick();
      check("cfg addr8 cfg_err clear", cfg_err, 0);
    end

    // Flush/valid collision: flush wins, then the impulse sequence repeats.
    flush = 1'b1; in_valid = 1'b1; in_sample = 16'sd5555;
    #1;
    check("coll in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("coll not accepted", busy, 0);
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].smp, tbl[i].expv, $sformatf("coll%0d", i));
    end

    // Reset in the middle of MAC.
    in_valid = 1'b1; in_sample = 16'sd8192;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst out_sample", $signed(out_sample), 0);
    check("midrst mul_b", mul_b, 0);
    check("midrst out_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst in_ready", in_ready, 1);
    send(16'sd8192, 16'sd0, "midrst coefs cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
